// File: rtl/cosine_pkg.sv
// Shared types and constants for the cosine-similarity vector loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cosine_pkg;

    // Loader FSM states; LOAD_A is the reset state.
    typedef enum logic [2:0] {
        ST_LOAD_A = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_FIRE   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } loader_state_t;

    // Quiet NaN returned as the result word when the engine times out.
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    // Default number of FP32 elements per vector.
    localparam int DEFAULT_W = 5;

endpackage

// File: rtl/cosine_vec_loader_if.sv
// Handshake/bus bundle between the word stream, the loader, the similarity engine
// and the result consumer. Latency: n/a (wires only).
// Backpressure: s_ready stalls the word stream, m_ready stalls the result.
// Ports (loader view, modport slave):
//   in : s_data/s_valid (word stream), sim_valid/sim_result (engine), m_ready
//   out: s_ready, vec_a/vec_b/start (to engine), m_data/m_err/m_valid, busy
interface cosine_vec_loader_if
    import cosine_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    logic [31:0]         s_data;
    logic                s_valid;
    logic                s_ready;
    logic [W-1:0][31:0]  vec_a;
    logic [W-1:0][31:0]  vec_b;
    logic                start;
    logic                sim_valid;
    logic [31:0]         sim_result;
    logic [31:0]         m_data;
    logic                m_err;
    logic                m_valid;
    logic                m_ready;
    logic                busy;

    // Loader side.
    modport slave (
        input  s_data, s_valid, sim_valid, sim_result, m_ready,
        output s_ready, vec_a, vec_b, start, m_data, m_err, m_valid, busy
    );

    // Environment side (stream source, engine, result sink).
    modport master (
        output s_data, s_valid, sim_valid, sim_result, m_ready,
        input  s_ready, vec_a, vec_b, start, m_data, m_err, m_valid, busy
    );

endinterface

// File: rtl/cosine_vec_loader.sv
// Loads two W-element FP32 vectors from a word stream, fires the similarity engine,
// then holds its result (or a timeout qNaN error) until the consumer takes it.
// Latency: start 1 cycle after the last vec_b word; m_valid 1 cycle after sim_valid.
// Backpressure: s_ready low outside LOAD_A/LOAD_B; result held in HOLD until m_ready.
// Ports: clk, rst (async active-high) plus bus (cosine_vec_loader_if.slave).
module cosine_vec_loader
    import cosine_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int TIMEOUT = 64
)(
    input  logic                 clk,
    input  logic                 rst,
    cosine_vec_loader_if.slave   bus
);

    localparam int IDXW = (W > 1) ? $clog2(W) : 1;
    localparam int CNTW = $clog2(TIMEOUT + 1);

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(W - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    loader_state_t        r_state;
    logic [IDXW-1:0]      r_idx;
    logic [CNTW-1:0]      r_cnt;
    logic [W-1:0][31:0]   r_vec_a;
    logic [W-1:0][31:0]   r_vec_b;
    logic                 r_start;
    logic                 r_s_ready;
    logic                 r_busy;
    logic [31:0]          r_m_data;
    logic                 r_m_err;
    logic                 r_m_valid;

    logic                 w_xfer;

    assign w_xfer = bus.s_valid && r_s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_LOAD_A;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_vec_a   <= '0;
            r_vec_b   <= '0;
            r_start   <= 1'b0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
            r_m_data  <= '0;
            r_m_err   <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            // start is a single-cycle pulse; only the LOAD_B exit raises it.
            r_start <= 1'b0;
            case (r_state)
                ST_LOAD_A: begin
                    if (w_xfer) begin
                        r_vec_a[r_idx] <= bus.s_data;
                        r_busy         <= 1'b1;
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= ST_LOAD_B;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (w_xfer) begin
                        r_vec_b[r_idx] <= bus.s_data;
                        if (r_idx == IDX_LAST) begin
                            r_idx     <= '0;
                            r_state   <= ST_FIRE;
                            r_start   <= 1'b1;
                            r_s_ready <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_FIRE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An engine result on the timeout cycle takes priority.
                    if (bus.sim_valid) begin
                        r_m_data  <= bus.sim_result;
                        r_m_err   <= 1'b0;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_HOLD;
                    end else if (r_cnt == CNT_LAST) begin
                        r_m_data  <= FP32_QNAN;
                        r_m_err   <= 1'b1;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_idx     <= '0;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_LOAD_A;
                    end
                end
                default: begin
                    r_state   <= ST_LOAD_A;
                    r_idx     <= '0;
                    r_s_ready <= 1'b1;
                    r_busy    <= 1'b0;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.vec_a   = r_vec_a;
    assign bus.vec_b   = r_vec_b;
    assign bus.start   = r_start;
    assign bus.m_data  = r_m_data;
    assign bus.m_err   = r_m_err;
    assign bus.m_valid = r_m_valid;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_cosine_vec_loader.sv
// Directed bench for cosine_vec_loader (W=5, TIMEOUT=4): basic job, stream
// backpressure, timeout, timeout/result race, HOLD stall and mid-job reset.
// Ports: drives the interface bundle and the plain clk/rst of the loader.
module tb_cosine_vec_loader;
    import cosine_pkg::*;

    localparam int W  = 5;
    localparam int TO = 4;

    logic clk;
    logic rst;

    cosine_vec_loader_if #(.W(W)) bus ();

    cosine_vec_loader #(.W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int start_cnt = 0;

    // Transfers and start pulses as seen at each rising edge.
    always @(posedge clk) begin
        if (bus.s_valid && bus.s_ready) xfer_cnt++;
        if (bus.start) start_cnt++;
    end

    logic [31:0] job [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream job[0..n-1]; with gap set, s_valid drops for one cycle between words.
    task automatic load_job(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = job[i];
            step();
            bus.s_valid = 1'b0;
            if (gap && i < n - 1) step();
        end
    endtask

    task automatic accept();
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("accept_m_valid", 32'(bus.m_valid), 32'd0);
        chk("accept_s_ready", 32'(bus.s_ready), 32'd1);
        chk("accept_busy",    32'(bus.busy),    32'd0);
    endtask

    int x0;
    int s0;
    logic [31:0] held;

    initial begin
        rst            = 1'b0;
        bus.s_data     = '0;
        bus.s_valid    = 1'b0;
        bus.sim_valid  = 1'b0;
        bus.sim_result = '0;
        bus.m_ready    = 1'b0;

        // Asynchronous reset, checked before the first clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_start",   32'(bus.start),   32'd0);
        chk("rst_m_data",  bus.m_data,       32'd0);
        chk("rst_m_err",   32'(bus.m_err),   32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("rst_vec_a0",  bus.vec_a[0],     32'd0);
        chk("rst_vec_b4",  bus.vec_b[4],     32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // sim_valid outside WAIT is ignored.
        bus.sim_valid  = 1'b1;
        bus.sim_result = 32'h1234_5678;
        step();
        bus.sim_valid  = 1'b0;
        chk("idle_sim_m_valid", 32'(bus.m_valid), 32'd0);
        chk("idle_sim_m_data",  bus.m_data,       32'd0);

        // Basic job: all ones, engine answers two cycles after start.
        for (int i = 0; i < 10; i++) job[i] = 32'h3F80_0000;
        s0 = start_cnt;
        load_job(10, 1'b0);
        chk("basic_start",   32'(bus.start),   32'd1);
        chk("basic_s_ready", 32'(bus.s_ready), 32'd0);
        chk("basic_busy",    32'(bus.busy),    32'd1);
        step();
        chk("basic_start_low", 32'(bus.start), 32'd0);
        step();
        bus.sim_valid  = 1'b1;
        bus.sim_result = 32'h3F80_0000;
        step();
        bus.sim_valid  = 1'b0;
        chk("basic_m_valid", 32'(bus.m_valid), 32'd1);
        chk("basic_m_data",  bus.m_data,       32'h3F80_0000);
        chk("basic_m_err",   32'(bus.m_err),   32'd0);
        chk("basic_one_start", 32'(start_cnt - s0), 32'd1);
        accept();

        // Backpressure: s_valid toggles every cycle, distinct words.
        for (int i = 0; i < 5; i++) job[i]     = 32'h4100_0000 + 32'(i);
        for (int i = 0; i < 5; i++) job[5 + i] = 32'h4200_0000 + 32'(i);
        x0 = xfer_cnt;
        load_job(10, 1'b1);
        chk("bp_start", 32'(bus.start), 32'd1);
        chk("bp_xfers", 32'(xfer_cnt - x0), 32'd10);
        for (int i = 0; i < 5; i++)
            chk($sformatf("bp_vec_a%0d", i), bus.vec_a[i], 32'h4100_0000 + 32'(i));
        chk("bp_vec_b4", bus.vec_b[4], 32'h4200_0004);

        // Timeout with no engine answer; stream words offered meanwhile are refused.
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hDEAD_BEEF;
        x0 = xfer_cnt;
        for (int i = 0; i < 4; i++) step();
        chk("to_early_m_valid", 32'(bus.m_valid), 32'd0);
        step();
        chk("to_m_valid", 32'(bus.m_valid), 32'd1);
        chk("to_m_data",  bus.m_data,       FP32_QNAN);
        chk("to_m_err",   32'(bus.m_err),   32'd1);
        chk("to_no_xfer", 32'(xfer_cnt - x0), 32'd0);
        chk("to_vec_a0_kept", bus.vec_a[0], 32'h4100_0000);
        bus.s_valid = 1'b0;
        accept();

        // Timeout race: result arrives on the timeout cycle and wins.
        for (int i = 0; i < 10; i++) job[i] = 32'h3E00_0000 + 32'(i);
        load_job(10, 1'b0);
        for (int i = 0; i < 4; i++) step();
        bus.sim_valid  = 1'b1;
        bus.sim_result = 32'h3F00_0000;
        step();
        bus.sim_valid  = 1'b0;
        chk("race_m_valid", 32'(bus.m_valid), 32'd1);
        chk("race_m_data",  bus.m_data,       32'h3F00_0000);
        chk("race_m_err",   32'(bus.m_err),   32'd0);
        accept();

        // HOLD stall for 7 cycles with stray sim_valid and s_valid.
        for (int i = 0; i < 10; i++) job[i] = 32'h4040_0000 + 32'(i);
        load_job(10, 1'b0);
        step();
        bus.sim_valid  = 1'b1;
        bus.sim_result = 32'h3E80_0000;
        step();
        bus.sim_valid  = 1'b0;
        held = 32'h3E80_0000;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hCAFE_0000;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                bus.sim_valid  = 1'b1;
                bus.sim_result = 32'h0BAD_0BAD;
            end else begin
                bus.sim_valid  = 1'b0;
            end
            chk($sformatf("hold_m_data_%0d", i),  bus.m_data,       held);
            chk($sformatf("hold_s_ready_%0d", i), 32'(bus.s_ready), 32'd0);
            chk($sformatf("hold_m_valid_%0d", i), 32'(bus.m_valid), 32'd1);
            step();
        end
        bus.sim_valid = 1'b0;
        bus.s_valid   = 1'b0;
        accept();
        for (int i = 0; i < 10; i++) job[i] = 32'h4500_0000 + 32'(i);
        load_job(10, 1'b0);
        chk("after_hold_start", 32'(bus.start), 32'd1);
        chk("after_hold_a0",    bus.vec_a[0],   32'h4500_0000);
        chk("after_hold_b4",    bus.vec_b[4],   32'h4500_0009);
        step();
        step();
        bus.sim_valid  = 1'b1;
        bus.sim_result = 32'h3F40_0000;
        step();
        bus.sim_valid  = 1'b0;
        chk("after_hold_m_data", bus.m_data, 32'h3F40_0000);
        accept();

        // Reset during LOAD_B after three words.
        for (int i = 0; i < 8; i++) job[i] = 32'h4700_0000 + 32'(i);
        load_job(8, 1'b0);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vec_a0",  bus.vec_a[0],     32'd0);
        chk("mid_rst_vec_b2",  bus.vec_b[2],     32'd0);
        chk("mid_rst_m_data",  bus.m_data,       32'd0);
        chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("mid_rst_start",   32'(bus.start),   32'd0);
        chk("mid_rst_busy",    32'(bus.busy),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int i = 0; i < 10; i++) job[i] = 32'h4800_0000 + 32'(i);
        s0 = start_cnt;
        load_job(9, 1'b0);
        chk("fresh_no_start_9", 32'(bus.start), 32'd0);
        bus.s_valid = 1'b1;
        bus.s_data  = job[9];
        step();
        bus.s_valid = 1'b0;
        chk("fresh_start",  32'(bus.start), 32'd1);
        chk("fresh_vec_a0", bus.vec_a[0],   32'h4800_0000);
        chk("fresh_vec_b0", bus.vec_b[0],   32'h4800_0005);
        chk("fresh_vec_b4", bus.vec_b[4],   32'h4800_0009);
        step();
        bus.sim_valid  = 1'b1;
        bus.sim_result = 32'h3F00_0001;
        step();
        bus.sim_valid  = 1'b0;
        chk("fresh_m_data", bus.m_data, 32'h3F00_0001);
        chk("fresh_one_start", 32'(start_cnt - s0), 32'd1);
        accept();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cosine_vec_loader.md
COSINE_VEC_LOADER -- requirements
Module: cosine_vec_loader

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter W, default 5: elements per vector, legal range 1..8.
REQ-003 Parameter TIMEOUT, default 64: maximum WAIT cycles before the error result, minimum 1.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 s_data  in  32  FP32 input word stream.
REQ-007 s_valid  in  1  s_data valid.
REQ-008 s_ready  out  1  loader accepts a word.
REQ-009 vec_a  out  W x 32  vector A to the similarity engine.
REQ-010 vec_b  out  W x 32  vector B to the similarity engine.
REQ-011 start  out  1  one-cycle compute request.
REQ-012 sim_valid  in  1  engine result strobe.
REQ-013 sim_result  in  32  engine FP32 similarity.
REQ-014 m_data  out  32  result word.
REQ-015 m_err  out  1  result is a timeout error.
REQ-016 m_valid  out  1  result valid.
REQ-017 m_ready  in  1  downstream accepts the result.
REQ-018 busy  out  1  high in every state except LOAD_A with index 0.

Function
REQ-019 A word transfer occurs on a rising edge where s_valid=1 and s_ready=1; no other condition transfers a word.
REQ-020 States: LOAD_A, LOAD_B, FIRE, WAIT, HOLD; the reset state is LOAD_A.
REQ-021 LOAD_A: s_ready=1; each transfer writes vec_a[idx] and increments idx; on the transfer with idx=W-1, idx clears and the FSM enters LOAD_B.
REQ-022 LOAD_B: s_ready=1; behaviour matches LOAD_A but writes vec_b; the transfer with idx=W-1 enters FIRE.
REQ-023 FIRE: start=1 for exactly that cycle, s_ready=0; the next state is WAIT, and the timeout counter clears on entry.
REQ-024 WAIT: s_ready=0; sim_valid=1 captures sim_result into m_data, sets m_err=0, and enters HOLD.
REQ-025 WAIT without sim_valid: the counter increments; when the counter equals TIMEOUT-1, m_data is set to 32'h7FC00000, m_err=1, and the FSM enters HOLD.
REQ-026 If sim_valid arrives in the same cycle as the timeout, sim_valid wins and m_err=0.
REQ-027 HOLD: m_valid=1 with m_data and m_err stable until an edge with m_ready=1; the FSM then enters LOAD_A with idx=0.
REQ-028 m_ready high on the first HOLD cycle completes the result in that single cycle.
REQ-029 vec_a and vec_b are unchanged in FIRE, WAIT and HOLD.
REQ-030 vec_a and vec_b are overwritten, not cleared, by the next job.
REQ-031 sim_valid outside WAIT is ignored.
REQ-032 s_valid while s_ready=0 is ignored; the word is not consumed.
REQ-033 Latency: start is high in the cycle after the final vec_b transfer, and m_valid rises in the cycle after sim_valid is sampled in WAIT.
REQ-034 No arithmetic is performed on data; words pass bit-exact.

Reset
REQ-035 rst=1 forces, without waiting for a clock edge, the following values: state LOAD_A, idx=0, counter=0, vec_a=0, vec_b=0, m_data=0, m_err=0, m_valid=0, start=0.
REQ-036 rst asserted mid-job discards partial vectors and any pending result; after release the loader accepts a new job from element a[0].

Structure
REQ-037 The shared package cosine_pkg SHALL hold: the loader_state_t enum, the FP32_QNAN constant 32'h7FC00000, and the default vector width 5.
REQ-038 Single module with no sub-modules; the idx width is $clog2(W) (minimum 1), and the counter width is $clog2(TIMEOUT+1).

Verification
REQ-039 Basic job: stream a=[3F800000 x5], b=[3F800000 x5]; respond with sim_valid two cycles after start, sim_result=3F800000 -> exactly one start pulse, then m_data=3F800000, m_err=0.
REQ-040 Backpressure: s_valid toggles 1/0 every cycle -> vec_a holds the words in order, and exactly 10 transfers occur before start.
REQ-041 Timeout with TIMEOUT=4 and no sim_valid -> m_valid four cycles after WAIT entry, m_data=7FC00000, m_err=1.
REQ-042 Timeout race: sim_valid=1 with sim_result=3F000000 on the timeout cycle -> m_data=3F000000, m_err=0.
REQ-043 HOLD stall: m_ready low for 7 cycles -> m_data stable and s_ready=0 throughout; the next job loads correctly after m_ready rises.
REQ-044 Reset during LOAD_B after 3 words -> all outputs zero, and the next 10 words form a fresh job.
